// File: rtl/mcyc_ctrl.sv
// rtl/mcyc_ctrl.sv - multicycle control FSM; define MCYC_DIV_EN to enable the DIV opcode
module mcyc_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int AW         = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [5:0]    op,
    input  logic [5:0]    funct,
    input  logic          mem_ready,
    input  logic          md_done,
    output logic          pcwrite,
    output logic          irwrite,
    output logic          iord,
    output logic          memread,
    output logic          memwrite,
    output logic          memtoreg,
    output logic          regwrite,
    output logic          regdst,
    output logic          alusrca,
    output logic          branch,
    output logic          jal,
    output logic          jr,
    output logic          sll,
    output logic          srl,
    output logic          lb,
    output logic          md_start,
    output logic          md_div,
    output logic          hilo_we,
    output logic          mflo,
    output logic          mfhi,
    output logic          illegal,
    output logic          md_timeout,
    output logic [1:0]    alusrcb,
    output logic [1:0]    pcsrc,
    output logic [AW-1:0] aluop,
    output logic [3:0]    state_o
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, ALUWB,
        ADDIEX, IMMWB, BEQ, JUMP, MDSTART, MDWAIT, HLWB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_SLL   = 6'b000101;
    localparam logic [5:0] OP_SRL   = 6'b000110;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_NOP   = 6'b001001;
    localparam logic [5:0] OP_MULT  = 6'b001010;
    localparam logic [5:0] OP_MFLO  = 6'b001011;
    localparam logic [5:0] OP_MFHI  = 6'b001100;
    localparam logic [5:0] OP_DIV   = 6'b001101;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [7:0] MD_LAST  = 8'(MD_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d, funct_q, funct_d;
    logic [7:0] cnt_q, cnt_d;
    logic       illegal_q, illegal_d, md_timeout_q, md_timeout_d;
    logic [1:0] aluop_c;
    logic       is_jr;

    assign is_jr = (op_q == OP_RTYPE) && (funct_q == FN_JR);

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        funct_d      = funct_q;
        cnt_d        = cnt_q;
        illegal_d    = illegal_q;
        md_timeout_d = md_timeout_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE;
            DECODE: begin
                // the instruction register is stable here, so capture op/funct for later states
                op_d    = op;
                funct_d = funct;
                case (op)
                    OP_LW, OP_SW, OP_LB:        state_d = MEMADR;
                    OP_RTYPE, OP_SLL, OP_SRL:   state_d = RTEX;
                    OP_ADDI:                    state_d = ADDIEX;
                    OP_BEQ:                     state_d = BEQ;
                    OP_J, OP_JAL:               state_d = JUMP;
                    OP_NOP:                     state_d = FETCH;
`ifdef MCYC_DIV_EN
                    OP_MULT, OP_DIV:            state_d = MDSTART;
`else
                    OP_MULT:                    state_d = MDSTART;
`endif
                    OP_MFLO, OP_MFHI:           state_d = HLWB;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = FETCH;
                    end
                endcase
            end
            MEMADR:  state_d = (op_q == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   if (mem_ready) state_d = MEMWB;
            MEMWR:   if (mem_ready) state_d = FETCH;
            RTEX:    state_d = is_jr ? FETCH : ALUWB;
            ADDIEX:  state_d = IMMWB;
            MDSTART: begin
                cnt_d   = 8'd0;
                state_d = MDWAIT;
            end
            MDWAIT: begin
                if (md_done) begin
                    state_d = FETCH;
                end else if (cnt_q == MD_LAST) begin
                    md_timeout_d = 1'b1;
                    state_d      = FETCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH;
            op_q         <= 6'd0;
            funct_q      <= 6'd0;
            cnt_q        <= 8'd0;
            illegal_q    <= 1'b0;
            md_timeout_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            funct_q      <= funct_d;
            cnt_q        <= cnt_d;
            illegal_q    <= illegal_d;
            md_timeout_q <= md_timeout_d;
        end
    end

    // Moore decode of the registered state; only handshake strobes look at mem_ready/md_done
    always_comb begin
        pcwrite = 1'b0; irwrite = 1'b0; iord = 1'b0; memread = 1'b0;
        memwrite = 1'b0; memtoreg = 1'b0; regwrite = 1'b0; regdst = 1'b0;
        alusrca = 1'b0; branch = 1'b0; jal = 1'b0; jr = 1'b0;
        sll = 1'b0; srl = 1'b0; lb = 1'b0; md_start = 1'b0;
        md_div = 1'b0; hilo_we = 1'b0; mflo = 1'b0; mfhi = 1'b0;
        alusrcb = 2'b00; pcsrc = 2'b00; aluop_c = 2'b00;
        if (reset) begin
            case (state_q)
                FETCH: begin
                    memread = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                DECODE:  alusrcb = 2'b11;
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                MEMRD: begin
                    iord    = 1'b1;
                    memread = 1'b1;
                end
                MEMWR: begin
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                    lb       = (op_q == OP_LB);
                end
                RTEX: begin
                    if (is_jr) begin
                        jr      = 1'b1;
                        pcsrc   = 2'b11;
                        pcwrite = 1'b1;
                    end else begin
                        alusrca = 1'b1;
                        aluop_c = 2'b10;
                        sll     = (op_q == OP_SLL);
                        srl     = (op_q == OP_SRL);
                    end
                end
                ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                IMMWB:   regwrite = 1'b1;
                BEQ: begin
                    alusrca = 1'b1;
                    aluop_c = 2'b01;
                    branch  = 1'b1;
                    pcsrc   = 2'b01;
                end
                JUMP: begin
                    pcsrc    = 2'b10;
                    pcwrite  = 1'b1;
                    jal      = (op_q == OP_JAL);
                    regwrite = (op_q == OP_JAL);
                    regdst   = (op_q == OP_JAL);
                end
                MDSTART: begin
                    md_start = 1'b1;
`ifdef MCYC_DIV_EN
                    md_div   = (op_q == OP_DIV);
`endif
                end
                MDWAIT:  hilo_we = md_done;
                HLWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                    mflo     = (op_q == OP_MFLO);
                    mfhi     = (op_q == OP_MFHI);
                end
                default: ;
            endcase
        end
    end

    assign aluop      = AW'(aluop_c);
    assign illegal    = illegal_q;
    assign md_timeout = md_timeout_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_mcyc_ctrl.sv
// tb/tb_mcyc_ctrl.sv - randomized bench for mcyc_ctrl against a per-instruction cycle model
module tb_mcyc_ctrl;
    localparam int TO = 8;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_SLL = 6'b000101, OP_SRL = 6'b000110;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_NOP = 6'b001001, OP_MULT = 6'b001010;
    localparam logic [5:0] OP_MFLO = 6'b001011, OP_MFHI = 6'b001100, OP_DIV = 6'b001101;
    localparam logic [5:0] OP_LB = 6'b100000, OP_LW = 6'b100011, OP_SW = 6'b101011;

    logic clk = 1'b0, reset = 1'b0;
    logic [5:0] op = 6'd0, funct = 6'd0;
    logic mem_ready = 1'b0, md_done = 1'b0;
    logic pcwrite, irwrite, iord, memread, memwrite, memtoreg, regwrite, regdst;
    logic alusrca, branch, jal, jr, sll, srl, lb, md_start, md_div, hilo_we;
    logic mflo, mfhi, illegal, md_timeout;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    mcyc_ctrl #(.MD_TIMEOUT(TO), .AW(2)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready), .md_done(md_done),
        .pcwrite(pcwrite), .irwrite(irwrite), .iord(iord), .memread(memread), .memwrite(memwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .regdst(regdst), .alusrca(alusrca), .branch(branch),
        .jal(jal), .jr(jr), .sll(sll), .srl(srl), .lb(lb), .md_start(md_start), .md_div(md_div),
        .hilo_we(hilo_we), .mflo(mflo), .mfhi(mfhi), .illegal(illegal), .md_timeout(md_timeout),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .state_o(state_o)
    );

    typedef struct packed {
        logic pcwrite, irwrite, iord, memread, memwrite, memtoreg, regwrite, regdst;
        logic alusrca, branch, jal, jr, sll, srl, lb, md_start, md_div, hilo_we, mflo, mfhi;
        logic [1:0] alusrcb, pcsrc, aluop;
        logic illegal, md_timeout;
    } ctl_t;

    typedef struct {
        ctl_t c;
        logic mr;
        logic mdd;
        logic [5:0] op;
        logic [5:0] fn;
    } step_t;

    step_t q[$];
    int n_cmp = 0, n_bad = 0;
    logic m_ill = 1'b0, m_mto = 1'b0;
    logic [5:0] cur_op, cur_fn;
    ctl_t obs;

    always_comb obs = {pcwrite, irwrite, iord, memread, memwrite, memtoreg, regwrite, regdst,
                       alusrca, branch, jal, jr, sll, srl, lb, md_start, md_div, hilo_we, mflo, mfhi,
                       alusrcb, pcsrc, aluop, illegal, md_timeout};

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic ctl_t base();
        ctl_t c = '0;
        c.illegal    = m_ill;
        c.md_timeout = m_mto;
        return c;
    endfunction

    function automatic logic legal(input logic [5:0] o);
        case (o)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_SLL, OP_SRL, OP_ADDI, OP_NOP, OP_MULT,
            OP_MFLO, OP_MFHI, OP_LB, OP_LW, OP_SW: return 1'b1;
`ifdef MCYC_DIV_EN
            OP_DIV: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input ctl_t c, input logic mr, input logic mdd);
        step_t s;
        s.c = c; s.mr = mr; s.mdd = mdd; s.op = cur_op; s.fn = cur_fn;
        q.push_back(s);
    endtask

    // Expected cycles for one instruction: fw fetch stalls, mw memory stalls, md_done on MDWAIT cycle mdat
    task automatic model(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw, input int mdat);
        ctl_t c;
        cur_op = o; cur_fn = f;
        for (int i = 0; i < fw; i++) begin
            c = base(); c.memread = 1; c.alusrcb = 2'b01; push(c, 1'b0, rb());
        end
        c = base(); c.memread = 1; c.alusrcb = 2'b01; c.irwrite = 1; c.pcwrite = 1; push(c, 1'b1, rb());
        c = base(); c.alusrcb = 2'b11; push(c, rb(), rb());
        if (!legal(o)) begin
            m_ill = 1'b1;
            return;
        end
        case (o)
            OP_LW, OP_LB, OP_SW: begin
                c = base(); c.alusrca = 1; c.alusrcb = 2'b10; push(c, rb(), rb());
                for (int i = 0; i <= mw; i++) begin
                    c = base(); c.iord = 1;
                    if (o == OP_SW) c.memwrite = 1; else c.memread = 1;
                    push(c, (i == mw), rb());
                end
                if (o != OP_SW) begin
                    c = base(); c.regwrite = 1; c.memtoreg = 1; c.lb = (o == OP_LB); push(c, rb(), rb());
                end
            end
            OP_RTYPE, OP_SLL, OP_SRL: begin
                if (o == OP_RTYPE && f == 6'b001000) begin
                    c = base(); c.jr = 1; c.pcsrc = 2'b11; c.pcwrite = 1; push(c, rb(), rb());
                end else begin
                    c = base(); c.alusrca = 1; c.aluop = 2'b10;
                    c.sll = (o == OP_SLL); c.srl = (o == OP_SRL); push(c, rb(), rb());
                    c = base(); c.regwrite = 1; c.regdst = 1; push(c, rb(), rb());
                end
            end
            OP_ADDI: begin
                c = base(); c.alusrca = 1; c.alusrcb = 2'b10; push(c, rb(), rb());
                c = base(); c.regwrite = 1; push(c, rb(), rb());
            end
            OP_BEQ: begin
                c = base(); c.alusrca = 1; c.aluop = 2'b01; c.branch = 1; c.pcsrc = 2'b01; push(c, rb(), rb());
            end
            OP_J, OP_JAL: begin
                c = base(); c.pcsrc = 2'b10; c.pcwrite = 1;
                if (o == OP_JAL) begin c.jal = 1; c.regwrite = 1; c.regdst = 1; end
                push(c, rb(), rb());
            end
            OP_MULT, OP_DIV: begin
                c = base(); c.md_start = 1; c.md_div = (o == OP_DIV); push(c, rb(), rb());
                for (int k = 1; k <= TO; k++) begin
                    c = base();
                    if (k == mdat) begin
                        c.hilo_we = 1; push(c, rb(), 1'b1);
                        break;
                    end
                    push(c, rb(), 1'b0);
                    if (k == TO) m_mto = 1'b1;
                end
            end
            OP_MFLO, OP_MFHI: begin
                c = base(); c.regwrite = 1; c.regdst = 1;
                c.mflo = (o == OP_MFLO); c.mfhi = (o == OP_MFHI); push(c, rb(), rb());
            end
            default: ;
        endcase
    endtask

    task automatic run_q(input string tag);
        step_t s;
        while (q.size() > 0) begin
            s = q.pop_front();
            @(posedge clk); #1;
            op = s.op; funct = s.fn; mem_ready = s.mr; md_done = s.mdd;
            @(negedge clk);
            check(tag, 32'(obs), 32'(s.c));
        end
    endtask

    task automatic reset_pulse(input string tag);
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1; md_done = 1'b1;
        #1 check({tag, "_now"}, 32'(obs), 32'd0);
        @(negedge clk);
        check({tag, "_hold"}, 32'(obs), 32'd0);
        check({tag, "_state"}, 32'(state_o), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = 1'b0; md_done = 1'b0;
        m_ill = 1'b0; m_mto = 1'b0;
    endtask

    logic [5:0] ops_tab [15];
    logic [5:0] ro, rf;

    initial begin
        ops_tab = '{OP_LW, OP_SW, OP_LB, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, OP_JAL,
                    OP_SLL, OP_SRL, OP_NOP, OP_MULT, OP_DIV, OP_MFLO, OP_MFHI};
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(obs), 32'd0);
        check("reset_state", 32'(state_o), 32'd0);
        @(posedge clk); #1 reset = 1'b1;

        model(OP_LW, 6'd0, 0, 3, 0);           run_q("lw_stall3");
        model(OP_RTYPE, 6'b001000, 0, 0, 0);   run_q("jr");
        model(OP_MULT, 6'd0, 1, 0, 5);         run_q("mult_done5");
        model(OP_MULT, 6'd0, 0, 0, 0);         run_q("mult_timeout");
        model(OP_NOP, 6'd0, 0, 0, 0);          run_q("after_timeout");
        model(6'b111111, 6'd0, 0, 0, 0);       run_q("illegal_op");
        model(OP_DIV, 6'd0, 0, 0, 3);          run_q("div");
        model(OP_BEQ, 6'd0, 0, 0, 0);          run_q("beq");
        model(OP_JAL, 6'd0, 0, 0, 0);          run_q("jal");
        model(OP_SW, 6'd0, 2, 1, 0);           run_q("sw");

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 15) == 15) begin
                do ro = 6'($urandom); while (legal(ro));
            end else begin
                ro = ops_tab[$urandom_range(0, 14)];
            end
            rf = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
            model(ro, rf, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 11));
            run_q("random");
        end

        // set both sticky flags, then abandon a MULT two cycles into MDWAIT
        model(6'b111111, 6'd0, 0, 0, 0);       run_q("pre_rst_ill");
        model(OP_MULT, 6'd0, 0, 0, 0);         run_q("pre_rst_to");
        model(OP_MULT, 6'd0, 0, 0, 0);
        while (q.size() > 5) void'(q.pop_back());
        run_q("mdwait_part");
        reset_pulse("rst_mdwait");
        model(OP_ADDI, 6'd0, 0, 0, 0);         run_q("post_rst_addi");

        model(OP_LW, 6'd0, 0, 6, 0);
        while (q.size() > 5) void'(q.pop_back());
        run_q("memrd_part");
        reset_pulse("rst_memrd");
        model(OP_MFHI, 6'd0, 1, 0, 0);         run_q("post_rst_mfhi");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
